instr_cache_direct: RTL and testbench
=====================================

// Module: instr_cache_direct
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the fetch stage (pc) and
//  instruction_main_memory. Hits return the instruction in the same cycle. A miss stalls
//  fetch, drives miss_cache/mem_addr to main memory, waits MEM_LATENCY cycles, then fills
//  the line and replays the instruction. A flush input supports fence.i.
// PARAMETERS
//  NUM_LINES    16  number of lines; power of 2, >=2; IDX_W = log2(NUM_LINES)
//  MEM_LATENCY  2   cycles from miss_cache assertion to sampling instr_from_main_mem; 1..15
//  CNT_W        16  width of the hit and miss statistics counters
// PORTS
//  clk                 in   1      rising-edge clock
//  reset               in   1      asynchronous, active-low reset
//  pc                  in   32     fetch address; word index = pc[31:2], pc[1:0] ignored
//  pc_valid            in   1      fetch request valid this cycle
//  flush               in   1      invalidate all lines (fence.i)
//  instr               out  32     instruction to decode
//  instr_valid         out  1      instr is valid for the current pc
//  stall               out  1      fetch must hold pc and pc_valid stable
//  miss_cache          out  1      refill in progress; main memory read enable
//  mem_addr            out  32     {pc[31:2],2'b00} during refill, else 0
//  instr_from_main_mem in   32     read data from main memory
//  hit_count           out  CNT_W  saturating count of hits
//  miss_count          out  CNT_W  saturating count of misses
// BEHAVIOUR
//  - Storage: valid[NUM_LINES], tag[NUM_LINES] = pc[31:2+IDX_W], data[NUM_LINES] (32 b).
//    Index = pc[2+IDX_W-1:2].
//  - Reset (reset=0, async): state=IDLE; all valid bits, counters, and registers are 0.
//    Outputs instr=0, instr_valid=0, stall=0, miss_cache=0, mem_addr=0.
//  - FSM states: IDLE, REFILL, REPLAY.
//  - IDLE, pc_valid=1, hit (line valid, tag match):
//    - instr=data[idx] and instr_valid=1 combinationally, with stall=0.
//    - hit_count increments.
//  - IDLE, pc_valid=1, miss:
//    - stall=1 combinationally; instr_valid=0.
//    - Next state is REFILL; the latency counter loads MEM_LATENCY-1.
//    - miss_count increments.
//  - IDLE, pc_valid=0: all outputs idle; no counter change.
//  - REFILL:
//    - Outputs: stall=1, miss_cache=1, mem_addr={pc[31:2],2'b00}.
//    - The counter decrements each cycle.
//    - On the cycle the counter is 0: sample instr_from_main_mem into data[idx], write the
//      tag, set valid[idx]=1, and go to REPLAY.
//    - Total refill is MEM_LATENCY cycles.
//  - REPLAY (1 cycle): instr=captured word, instr_valid=1, stall=0; then IDLE.
//    - Miss latency from the pc_valid cycle to instr_valid is MEM_LATENCY+1 cycles.
//  - Flush in any state: all valid bits clear at the next edge.
//    - In IDLE, a flush cycle is treated as a miss-free bubble: no hit is reported and
//      instr_valid=0 (flush has priority over lookup).
//    - In REFILL, the refill aborts with no line written. Next state is IDLE with
//      stall=0; fetch re-presents pc.
//    - In REPLAY, the replayed instruction is still delivered; the line is invalidated.
//  - Counters saturate at all ones and do not wrap.
//  - Conflict eviction: a refill overwrites the line unconditionally (no replacement choice).
//  - pc change while stall=1 is a protocol violation; behaviour is unspecified.
//  - No write path; main memory is read-only from this block.
// TESTING
//  - Cold miss, MEM_LATENCY=2: pc=0x00 with mem[0]=0x00500093.
//    -> stall=1 and miss_cache=1 for 2 cycles, mem_addr=0.
//    -> Then instr=0x00500093 with instr_valid=1; miss_count=1.
//  - Hit after fill: pc=0x00 again.
//    -> instr_valid=1 in the same cycle, stall=0; hit_count=1, with no miss_cache pulse.
//  - Conflict, NUM_LINES=16: pc=0x04 fill, then pc=0x44 (same index 1, different tag).
//    -> The second access misses, then refetch of 0x04 misses again; miss_count=3.
//  - Flush mid-refill: assert flush on the 1st REFILL cycle of pc=0x08.
//    -> Next cycle stall=0 and miss_cache=0, no instr_valid.
//    -> Re-request 0x08 misses; earlier line 0x00 also misses after the flush.
//  - Async reset: drop reset during REFILL, between clock edges.
//    -> Outputs go to 0 immediately; after release, pc=0x00 misses (valid bits cleared).
//  - Saturation, CNT_W=4: 20 hits to pc=0x00.
//    -> hit_count holds 4'hF.

Source files
------------

// File: rtl/instr_cache_direct_if.sv
// Fetch/memory-side bundle for the direct-mapped instruction cache.
// master = fetch stage plus main memory; slave = the cache.
interface instr_cache_direct_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      pc;
  logic             pc_valid;
  logic             flush;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             stall;
  logic             miss_cache;
  logic [31:0]      mem_addr;
  logic [31:0]      instr_from_main_mem;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output pc, pc_valid, flush, instr_from_main_mem,
    input  instr, instr_valid, stall, miss_cache, mem_addr, hit_count, miss_count
  );

  modport slave (
    input  pc, pc_valid, flush, instr_from_main_mem,
    output instr, instr_valid, stall, miss_cache, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/instr_cache_direct.sv
// Direct-mapped, one-word-per-line instruction cache: same-cycle hits, stalling
// refill from main memory with fixed latency, and fence.i-style flush.
module instr_cache_direct #(
  parameter int NUM_LINES   = 16,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input logic                 clk,
  input logic                 reset,
  instr_cache_direct_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, REPLAY} state_t;

  state_t               state_reg;
  logic [3:0]           lat_cnt_reg;
  logic [NUM_LINES-1:0] valid_reg;
  logic [31:0]          replay_word_reg;
  logic [CNT_W-1:0]     hit_count_reg;
  logic [CNT_W-1:0]     miss_count_reg;

  logic [TAG_W-1:0]     tag_mem [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES];

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     pc_tag;
  logic                 line_hit;
  logic                 lookup;
  logic                 do_hit;
  logic                 do_miss;
  logic                 fill;

  assign idx      = bus.pc[2 +: IDX_W];
  assign pc_tag   = bus.pc[31:2+IDX_W];
  assign line_hit = valid_reg[idx] && (tag_mem[idx] == pc_tag);
  // Flush wins over lookup: a flush cycle in IDLE is neither a hit nor a miss.
  assign lookup   = (state_reg == IDLE) && bus.pc_valid && !bus.flush;
  assign do_hit   = lookup && line_hit;
  assign do_miss  = lookup && !line_hit;
  assign fill     = (state_reg == REFILL) && !bus.flush && (lat_cnt_reg == 4'd0);

  // Outputs are forced idle while reset is held so they drop without a clock edge.
  always_comb begin
    bus.instr       = 32'd0;
    bus.instr_valid = 1'b0;
    bus.stall       = 1'b0;
    bus.miss_cache  = 1'b0;
    bus.mem_addr    = 32'd0;
    if (reset) begin
      unique case (state_reg)
        IDLE: begin
          if (do_hit) begin
            bus.instr       = data_mem[idx];
            bus.instr_valid = 1'b1;
          end
          bus.stall = do_miss;
        end
        REFILL: begin
          bus.stall      = 1'b1;
          bus.miss_cache = 1'b1;
          bus.mem_addr   = bus.pc & 32'hFFFF_FFFC;
        end
        REPLAY: begin
          bus.instr       = replay_word_reg;
          bus.instr_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hit_count  = hit_count_reg;
  assign bus.miss_count = miss_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      lat_cnt_reg     <= 4'd0;
      valid_reg       <= '0;
      replay_word_reg <= 32'd0;
      hit_count_reg   <= '0;
      miss_count_reg  <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (do_miss) begin
            state_reg   <= REFILL;
            lat_cnt_reg <= 4'(MEM_LATENCY - 1);
          end
        end
        REFILL: begin
          if (bus.flush) begin
            state_reg <= IDLE;
          end else if (lat_cnt_reg == 4'd0) begin
            state_reg       <= REPLAY;
            replay_word_reg <= bus.instr_from_main_mem;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        REPLAY:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (bus.flush)
        valid_reg <= '0;
      else if (fill)
        valid_reg[idx] <= 1'b1;

      if (do_hit && (hit_count_reg != '1))
        hit_count_reg <= hit_count_reg + CNT_W'(1);
      if (do_miss && (miss_count_reg != '1))
        miss_count_reg <= miss_count_reg + CNT_W'(1);
    end
  end

  // Line storage carries no reset; valid_reg alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[idx] <= bus.instr_from_main_mem;
      tag_mem[idx]  <= pc_tag;
    end
  end
endmodule

// File: tb/tb_instr_cache_direct.sv
// Directed plus randomized checks of instr_cache_direct against a resident-address
// model of a 16-line direct-mapped cache with saturating 4-bit statistics.
module tb_instr_cache_direct;
  localparam int NUM_LINES = 16;
  localparam int LAT       = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  instr_cache_direct_if #(.CNT_W(CNT_W)) bus ();

  instr_cache_direct #(
    .NUM_LINES  (NUM_LINES),
    .MEM_LATENCY(LAT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Main memory only answers while the cache requests a read.
  assign bus.instr_from_main_mem = bus.miss_cache ? memfn(bus.mem_addr) : 32'hDEAD_BEEF;

  // Model: which word address lives in each line, plus hit/miss tallies.
  bit   [NUM_LINES-1:0] m_valid;
  logic [29:0]          m_word [NUM_LINES];
  int                   m_hits;
  int                   m_misses;

  int passed;
  int total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic model_clear();
    m_valid  = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b0;
    bus.pc_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.pc       = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic fetch(input logic [31:0] addr, input bit flush_replay);
    logic [29:0] w;
    int          line;
    logic [31:0] exp_d;
    bit          hit;
    w     = addr[31:2];
    line  = int'(w % NUM_LINES);
    exp_d = memfn({w, 2'b00});
    hit   = m_valid[line] && (m_word[line] == w);
    @(negedge clk);
    bus.pc       = addr;
    bus.pc_valid = 1'b1;
    bus.flush    = 1'b0;
    #1;
    chk("hit_count", 32'(bus.hit_count), 32'(m_hits));
    chk("miss_count", 32'(bus.miss_count), 32'(m_misses));
    if (hit) begin
      chk("hit_valid", 32'(bus.instr_valid), 32'd1);
      chk("hit_instr", bus.instr, exp_d);
      chk("hit_stall", 32'(bus.stall), 32'd0);
      chk("hit_miss_cache", 32'(bus.miss_cache), 32'd0);
      if (m_hits < CNT_MAX) m_hits++;
    end else begin
      chk("miss_stall", 32'(bus.stall), 32'd1);
      chk("miss_ivalid", 32'(bus.instr_valid), 32'd0);
      if (m_misses < CNT_MAX) m_misses++;
      for (int k = 0; k < LAT; k++) begin
        @(negedge clk);
        #1;
        chk("refill_stall", 32'(bus.stall), 32'd1);
        chk("refill_miss_cache", 32'(bus.miss_cache), 32'd1);
        chk("refill_mem_addr", bus.mem_addr, {w, 2'b00});
        chk("refill_ivalid", 32'(bus.instr_valid), 32'd0);
      end
      @(negedge clk);
      bus.flush = flush_replay;
      #1;
      chk("replay_valid", 32'(bus.instr_valid), 32'd1);
      chk("replay_instr", bus.instr, exp_d);
      chk("replay_stall", 32'(bus.stall), 32'd0);
      chk("replay_miss_cache", 32'(bus.miss_cache), 32'd0);
      m_valid[line] = 1'b1;
      m_word[line]  = w;
      if (flush_replay) m_valid = '0;
    end
    $display("fetch pc=%h hit=%0d flush_replay=%0d instr=%h hits=%0d misses=%0d",
             addr, hit, flush_replay, exp_d, m_hits, m_misses);
  endtask

  task automatic bubble(input bit with_flush, input logic [31:0] addr);
    @(negedge clk);
    bus.pc       = addr;
    bus.pc_valid = with_flush;
    bus.flush    = with_flush;
    #1;
    chk("bubble_ivalid", 32'(bus.instr_valid), 32'd0);
    chk("bubble_stall", 32'(bus.stall), 32'd0);
    chk("bubble_miss_cache", 32'(bus.miss_cache), 32'd0);
    chk("bubble_mem_addr", bus.mem_addr, 32'd0);
    if (with_flush) m_valid = '0;
    $display("bubble pc=%h flush=%0d", addr, with_flush);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    reset        = 1'b0;
    bus.pc       = 32'd0;
    bus.pc_valid = 1'b0;
    bus.flush    = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_ivalid", 32'(bus.instr_valid), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_miss_cache", 32'(bus.miss_cache), 32'd0);
    chk("rst_hit_count", 32'(bus.hit_count), 32'd0);
    chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
    reset = 1'b1;
    $display("reset released");

    // Cold miss then hit on 0x00
    fetch(32'h00, 1'b0);
    fetch(32'h00, 1'b0);
    bubble(1'b0, 32'h0);
    chk("cold_miss_count", 32'(bus.miss_count), 32'd1);
    chk("cold_hit_count", 32'(bus.hit_count), 32'd1);

    // Conflict on index 1
    do_reset();
    fetch(32'h04, 1'b0);
    fetch(32'h44, 1'b0);
    fetch(32'h04, 1'b0);
    bubble(1'b0, 32'h0);
    chk("conflict_miss_count", 32'(bus.miss_count), 32'd3);

    // Flush on the first refill cycle of 0x08
    do_reset();
    fetch(32'h00, 1'b0);
    @(negedge clk);
    bus.pc = 32'h08; bus.pc_valid = 1'b1; bus.flush = 1'b0;
    #1;
    chk("fl_miss_stall", 32'(bus.stall), 32'd1);
    if (m_misses < CNT_MAX) m_misses++;
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("fl_refill_miss_cache", 32'(bus.miss_cache), 32'd1);
    m_valid = '0;
    @(negedge clk);
    bus.flush = 1'b0; bus.pc_valid = 1'b0;
    #1;
    chk("fl_after_stall", 32'(bus.stall), 32'd0);
    chk("fl_after_miss_cache", 32'(bus.miss_cache), 32'd0);
    chk("fl_after_ivalid", 32'(bus.instr_valid), 32'd0);
    $display("flush mid-refill pc=00000008");
    fetch(32'h08, 1'b0);
    fetch(32'h00, 1'b0);
    // Flush during replay still delivers, then the line is gone
    fetch(32'h10, 1'b1);
    fetch(32'h10, 1'b0);

    // Async reset during refill
    do_reset();
    fetch(32'h00, 1'b0);
    fetch(32'h00, 1'b0);
    @(negedge clk);
    bus.pc = 32'h20; bus.pc_valid = 1'b1; bus.flush = 1'b0;
    @(negedge clk);
    #1;
    chk("ar_pre_miss_cache", 32'(bus.miss_cache), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_stall", 32'(bus.stall), 32'd0);
    chk("ar_miss_cache", 32'(bus.miss_cache), 32'd0);
    chk("ar_mem_addr", bus.mem_addr, 32'd0);
    chk("ar_ivalid", 32'(bus.instr_valid), 32'd0);
    chk("ar_hit_count", 32'(bus.hit_count), 32'd0);
    chk("ar_miss_count", 32'(bus.miss_count), 32'd0);
    $display("async reset during refill");
    model_clear();
    @(negedge clk);
    bus.pc_valid = 1'b0;
    reset = 1'b1;
    fetch(32'h00, 1'b0);
    bubble(1'b0, 32'h0);
    chk("ar_refetch_miss", 32'(bus.miss_count), 32'd1);

    // Hit counter saturation
    do_reset();
    fetch(32'h00, 1'b0);
    for (int i = 0; i < 20; i++) fetch(32'h00, 1'b0);
    bubble(1'b0, 32'h0);
    chk("sat_hit_count", 32'(bus.hit_count), 32'hF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 80; i++) begin
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      a = (32'($urandom_range(0, 7)) + 32'd16 * 32'($urandom_range(0, 2))) * 32'd4
          + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      if (r == 0)      bubble(1'b1, a);
      else if (r == 1) bubble(1'b0, a);
      else             fetch(a, r == 2);
    end
    bubble(1'b0, 32'h0);
    chk("rand_hit_count", 32'(bus.hit_count), 32'(m_hits));
    chk("rand_miss_count", 32'(bus.miss_count), 32'(m_misses));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
